// File: rtl/fir_coeff_loader.sv
// Writer side of the FIR coefficient-update interface: takes a run of host
// coefficients, writes them to addresses 0..N-1 and then commits the count.
module fir_coeff_loader #(
  parameter int MAX_COEFF = 40,
  parameter int CW        = 16,
  parameter int AW        = 6
) (
  input  logic          iClk12M,
  input  logic          iRsn,
  input  logic          iEnSample600k,
  input  logic          iLoadStart,
  input  logic [AW-1:0] iLoadNum,
  input  logic          iLoadAbort,
  input  logic          iCoeffValid,
  input  logic [CW-1:0] iCoeffData,
  output logic          oCoeffReady,
  output logic          oCoeffUpdateFlag,
  output logic [AW-1:0] oNumOfCoeff,
  output logic [AW-1:0] oAddrRam,
  output logic [CW-1:0] oWrDtRam,
  output logic          oBusy,
  output logic          oDone,
  output logic          oErr
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
  localparam logic [1:0] ST_LOAD      = 2'd2;
  localparam logic [1:0] ST_FINISH    = 2'd3;

  localparam logic [AW-1:0] MAX_NUM = AW'(MAX_COEFF);

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] pending_q, pending_d;
  logic [AW-1:0] cnt_q,     cnt_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [CW-1:0] data_q,    data_d;
  logic [AW-1:0] num_q,     num_d;
  logic          flag_q,    flag_d;
  logic          done_q,    done_d;
  logic          err_q,     err_d;

  // Abort outranks a transfer; the strobe only matters while waiting for sync.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    num_d     = num_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iLoadStart) begin
          if ((iLoadNum != '0) && (iLoadNum <= MAX_NUM)) begin
            pending_d = iLoadNum;
            cnt_d     = '0;
            state_d   = ST_WAIT_SYNC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT_SYNC: begin
        if (iLoadAbort) begin
          state_d = ST_IDLE;
        end else if (iEnSample600k) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (iLoadAbort) begin
          state_d = ST_IDLE;
        end else if (iCoeffValid) begin
          addr_d = cnt_q;
          data_d = iCoeffData;
          // Wrap the counter on the last beat so it never reaches MAX_COEFF.
          if (cnt_q == pending_q - 1'b1) begin
            cnt_d   = '0;
            state_d = ST_FINISH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        if (!iLoadAbort) begin
          num_d  = pending_q;
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The filter stays in update mode through LOAD and the one FINISH cycle.
    flag_d = (state_d == ST_LOAD) || (state_d == ST_FINISH);
  end

  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      num_q     <= '0;
      flag_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      num_q     <= num_d;
      flag_q    <= flag_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign oCoeffReady      = (state_q == ST_LOAD);
  assign oBusy            = (state_q != ST_IDLE);
  assign oCoeffUpdateFlag = flag_q;
  assign oNumOfCoeff      = num_q;
  assign oAddrRam         = addr_q;
  assign oWrDtRam         = data_q;
  assign oDone            = done_q;
  assign oErr             = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: expected address/data pairs are
// queued when a beat is accepted and compared the cycle after.
module tb_fir_coeff_loader;

  localparam int MAX_COEFF = 40;
  localparam int CW        = 16;
  localparam int AW        = 6;

  logic          clk = 1'b0;
  logic          iRsn;
  logic          iEnSample600k;
  logic          iLoadStart;
  logic [AW-1:0] iLoadNum;
  logic          iLoadAbort;
  logic          iCoeffValid;
  logic [CW-1:0] iCoeffData;
  logic          oCoeffReady;
  logic          oCoeffUpdateFlag;
  logic [AW-1:0] oNumOfCoeff;
  logic [AW-1:0] oAddrRam;
  logic [CW-1:0] oWrDtRam;
  logic          oBusy;
  logic          oDone;
  logic          oErr;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  logic [AW+CW-1:0] sb[$];
  logic [AW-1:0] exp_addr = '0;
  logic xfer_prev = 1'b0;

  always #41 clk = ~clk;

  fir_coeff_loader #(.MAX_COEFF(MAX_COEFF), .CW(CW), .AW(AW)) dut (
    .iClk12M(clk), .iRsn(iRsn), .iEnSample600k(iEnSample600k),
    .iLoadStart(iLoadStart), .iLoadNum(iLoadNum), .iLoadAbort(iLoadAbort),
    .iCoeffValid(iCoeffValid), .iCoeffData(iCoeffData),
    .oCoeffReady(oCoeffReady), .oCoeffUpdateFlag(oCoeffUpdateFlag),
    .oNumOfCoeff(oNumOfCoeff), .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  // Write monitor: an accepted beat must show its address/data one cycle later.
  always @(posedge clk)
    xfer_prev <= iRsn && !iLoadAbort && iCoeffValid && oCoeffReady;

  always @(negedge clk) begin
    logic [AW+CW-1:0] exp;
    if (xfer_prev) begin
      writes_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", oAddrRam, oWrDtRam);
      end else begin
        exp = sb.pop_front();
        if ({oAddrRam, oWrDtRam} !== exp) begin
          errors++;
          $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                   oAddrRam, oWrDtRam, exp[AW+CW-1:CW], exp[CW-1:0]);
        end
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] n);
    iLoadStart = 1'b1;
    iLoadNum   = n;
    @(negedge clk);
    iLoadStart = 1'b0;
  endtask

  task automatic do_strobe();
    iEnSample600k = 1'b1;
    @(negedge clk);
    iEnSample600k = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit rnd);
    int sent = 0;
    logic acc;
    logic [CW-1:0] d;
    for (int c = 0; c < 4000 && sent < n; c++) begin
      iCoeffValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      d = rnd ? CW'($urandom) : CW'((sent + 1) * 17);
      iCoeffData = d;
      acc = iCoeffValid && oCoeffReady;
      @(posedge clk);
      if (acc) begin
        sb.push_back({exp_addr, d});
        exp_addr++;
        sent++;
      end
      @(negedge clk);
    end
    iCoeffValid = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL beats_accepted: got %0d, required %0d within cycle budget", sent, n);
    end
  endtask

  task automatic test_reset();
    iRsn = 1'b0;
    repeat (3) @(negedge clk);
    checks += 8;
    if (oCoeffReady !== 1'b0)      begin errors++; $display("FAIL reset_ready: got %b, required 0", oCoeffReady); end
    if (oCoeffUpdateFlag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b, required 0", oCoeffUpdateFlag); end
    if (oNumOfCoeff !== '0)        begin errors++; $display("FAIL reset_num: got %0d, required 0", oNumOfCoeff); end
    if (oAddrRam !== '0)           begin errors++; $display("FAIL reset_addr: got %0d, required 0", oAddrRam); end
    if (oWrDtRam !== '0)           begin errors++; $display("FAIL reset_data: got %h, required 0", oWrDtRam); end
    if (oBusy !== 1'b0)            begin errors++; $display("FAIL reset_busy: got %b, required 0", oBusy); end
    if (oDone !== 1'b0)            begin errors++; $display("FAIL reset_done: got %b, required 0", oDone); end
    if (oErr !== 1'b0)             begin errors++; $display("FAIL reset_err: got %b, required 0", oErr); end
    iRsn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load4();
    do_start(6'd4);
    exp_addr = '0;
    @(negedge clk);
    @(negedge clk);
    checks += 3;
    if (oBusy !== 1'b1)            begin errors++; $display("FAIL wait_busy: got %b, required 1", oBusy); end
    if (oCoeffUpdateFlag !== 1'b0) begin errors++; $display("FAIL wait_flag: got %b, required 0", oCoeffUpdateFlag); end
    if (oCoeffReady !== 1'b0)      begin errors++; $display("FAIL wait_ready: got %b, required 0", oCoeffReady); end
    do_strobe();
    checks += 2;
    if (oCoeffUpdateFlag !== 1'b1) begin errors++; $display("FAIL load4_flag_rise: got %b, required 1", oCoeffUpdateFlag); end
    if (oCoeffReady !== 1'b1)      begin errors++; $display("FAIL load4_ready: got %b, required 1", oCoeffReady); end
    send_beats(4, 1'b0);
    checks += 3;
    if (oCoeffUpdateFlag !== 1'b1) begin errors++; $display("FAIL finish_flag: got %b, required 1", oCoeffUpdateFlag); end
    if (oCoeffReady !== 1'b0)      begin errors++; $display("FAIL finish_ready: got %b, required 0", oCoeffReady); end
    if (oDone !== 1'b0)            begin errors++; $display("FAIL finish_done_early: got %b, required 0", oDone); end
    @(negedge clk);
    checks += 4;
    if (oCoeffUpdateFlag !== 1'b0) begin errors++; $display("FAIL load4_flag_fall: got %b, required 0", oCoeffUpdateFlag); end
    if (oDone !== 1'b1)            begin errors++; $display("FAIL load4_done: got %b, required 1", oDone); end
    if (oNumOfCoeff !== 6'd4)      begin errors++; $display("FAIL load4_num: got %0d, required 4", oNumOfCoeff); end
    if (oBusy !== 1'b0)            begin errors++; $display("FAIL load4_busy: got %b, required 0", oBusy); end
    @(negedge clk);
    checks += 2;
    if (oDone !== 1'b0)            begin errors++; $display("FAIL load4_done_width: got %b, required 0", oDone); end
    if (sb.size() != 0)            begin errors++; $display("FAIL load4_sb_empty: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_load40_random();
    int w0 = writes_seen;
    do_start(6'd40);
    exp_addr = '0;
    @(negedge clk);
    do_strobe();
    send_beats(40, 1'b1);
    checks++;
    if (oCoeffReady !== 1'b0)      begin errors++; $display("FAIL load40_ready_after: got %b, required 0", oCoeffReady); end
    @(negedge clk);
    checks += 4;
    if (oDone !== 1'b1)            begin errors++; $display("FAIL load40_done: got %b, required 1", oDone); end
    if (oNumOfCoeff !== 6'd40)     begin errors++; $display("FAIL load40_num: got %0d, required 40", oNumOfCoeff); end
    if (writes_seen - w0 != 40)    begin errors++; $display("FAIL load40_write_count: got %0d, required 40", writes_seen - w0); end
    if (sb.size() != 0)            begin errors++; $display("FAIL load40_sb_empty: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reject();
    logic [AW-1:0] bad[2] = '{6'd0, 6'd41};
    for (int i = 0; i < 2; i++) begin
      do_start(bad[i]);
      checks += 3;
      if (oErr !== 1'b1)             begin errors++; $display("FAIL reject_err n=%0d: got %b, required 1", bad[i], oErr); end
      if (oBusy !== 1'b0)            begin errors++; $display("FAIL reject_busy n=%0d: got %b, required 0", bad[i], oBusy); end
      if (oCoeffUpdateFlag !== 1'b0) begin errors++; $display("FAIL reject_flag n=%0d: got %b, required 0", bad[i], oCoeffUpdateFlag); end
      @(negedge clk);
      checks += 2;
      if (oErr !== 1'b0)             begin errors++; $display("FAIL reject_err_width n=%0d: got %b, required 0", bad[i], oErr); end
      if (oBusy !== 1'b0)            begin errors++; $display("FAIL reject_busy_after n=%0d: got %b, required 0", bad[i], oBusy); end
    end
  endtask

  task automatic test_abort();
    bit done_seen = 1'b0;
    do_start(6'd10);
    exp_addr = '0;
    do_strobe();
    send_beats(5, 1'b0);
    iLoadAbort = 1'b1;
    @(negedge clk);
    iLoadAbort = 1'b0;
    checks += 3;
    if (oCoeffUpdateFlag !== 1'b0) begin errors++; $display("FAIL abort_flag: got %b, required 0", oCoeffUpdateFlag); end
    if (oBusy !== 1'b0)            begin errors++; $display("FAIL abort_busy: got %b, required 0", oBusy); end
    if (oNumOfCoeff !== 6'd40)     begin errors++; $display("FAIL abort_num_kept: got %0d, required 40", oNumOfCoeff); end
    for (int c = 0; c < 4; c++) begin
      if (oDone) done_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (done_seen)                 begin errors++; $display("FAIL abort_no_done: got done pulse, required none"); end
    do_start(6'd10);
    exp_addr = '0;
    do_strobe();
    send_beats(10, 1'b0);
    @(negedge clk);
    checks += 3;
    if (oDone !== 1'b1)            begin errors++; $display("FAIL reload_done: got %b, required 1", oDone); end
    if (oNumOfCoeff !== 6'd10)     begin errors++; $display("FAIL reload_num: got %0d, required 10", oNumOfCoeff); end
    if (sb.size() != 0)            begin errors++; $display("FAIL reload_sb_empty: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_ignored_inputs();
    do_start(6'd7);
    exp_addr = '0;
    @(negedge clk);
    do_start(6'd3);
    checks += 2;
    if (oBusy !== 1'b1)            begin errors++; $display("FAIL restart_busy: got %b, required 1", oBusy); end
    if (oErr !== 1'b0)             begin errors++; $display("FAIL restart_err: got %b, required 0", oErr); end
    do_strobe();
    send_beats(3, 1'b0);
    do_strobe();
    checks += 2;
    if (oCoeffReady !== 1'b1)      begin errors++; $display("FAIL strobe_in_load_ready: got %b, required 1", oCoeffReady); end
    if (oCoeffUpdateFlag !== 1'b1) begin errors++; $display("FAIL strobe_in_load_flag: got %b, required 1", oCoeffUpdateFlag); end
    send_beats(4, 1'b0);
    @(negedge clk);
    checks += 2;
    if (oDone !== 1'b1)            begin errors++; $display("FAIL ignore_done: got %b, required 1", oDone); end
    if (oNumOfCoeff !== 6'd7)      begin errors++; $display("FAIL ignore_num: got %0d, required 7", oNumOfCoeff); end
  endtask

  task automatic test_reset_mid_load();
    do_start(6'd5);
    exp_addr = '0;
    do_strobe();
    send_beats(2, 1'b0);
    iRsn = 1'b0;
    @(negedge clk);
    checks += 7;
    if (oCoeffUpdateFlag !== 1'b0) begin errors++; $display("FAIL midrst_flag: got %b, required 0", oCoeffUpdateFlag); end
    if (oCoeffReady !== 1'b0)      begin errors++; $display("FAIL midrst_ready: got %b, required 0", oCoeffReady); end
    if (oBusy !== 1'b0)            begin errors++; $display("FAIL midrst_busy: got %b, required 0", oBusy); end
    if (oNumOfCoeff !== '0)        begin errors++; $display("FAIL midrst_num: got %0d, required 0", oNumOfCoeff); end
    if (oAddrRam !== '0)           begin errors++; $display("FAIL midrst_addr: got %0d, required 0", oAddrRam); end
    if (oWrDtRam !== '0)           begin errors++; $display("FAIL midrst_data: got %h, required 0", oWrDtRam); end
    if (oDone !== 1'b0)            begin errors++; $display("FAIL midrst_done: got %b, required 0", oDone); end
    iRsn = 1'b1;
    @(negedge clk);
    checks += 2;
    if (oDone !== 1'b0)            begin errors++; $display("FAIL midrst_done_after: got %b, required 0", oDone); end
    if (oBusy !== 1'b0)            begin errors++; $display("FAIL midrst_busy_after: got %b, required 0", oBusy); end
  endtask

  initial begin
    iRsn          = 1'b0;
    iEnSample600k = 1'b0;
    iLoadStart    = 1'b0;
    iLoadNum      = '0;
    iLoadAbort    = 1'b0;
    iCoeffValid   = 1'b0;
    iCoeffData    = '0;
    test_reset();
    test_load4();
    test_load40_random();
    test_reject();
    test_abort();
    test_ignored_inputs();
    test_reset_mid_load();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Writer side of the FIR coefficient-update interface. Drives the filter's update-flag, address, data and coefficient-count inputs.
- Accepts a run of 16-bit coefficients from a host over a valid/ready handshake.
- Starts each load only on a 600kHz sample boundary, so the filter is never switched into update mode mid-computation.
- Writes coefficients to linear addresses 0..N-1, then commits the new count to the filter.

Parameters:
- MAX_COEFF, 40, largest legal coefficient count (filter tap count)
- CW, 16, coefficient width
- AW, 6, address and count width

Ports:
- iClk12M  in  1  12MHz system clock; the only clock
- iRsn  in  1  reset; synchronous, active-low, sampled on rising edge of iClk12M
- iEnSample600k  in  1  600kHz sample strobe, one cycle wide
- iLoadStart  in  1  one-cycle request to begin a load session
- iLoadNum  in  AW  number of coefficients to load in this session
- iLoadAbort  in  1  cancels the active session
- iCoeffValid  in  1  host coefficient valid
- iCoeffData  in  CW  host coefficient
- oCoeffReady  out  1  loader can accept a coefficient
- oCoeffUpdateFlag  out  1  filter update-mode flag
- oNumOfCoeff  out  AW  committed coefficient count
- oAddrRam  out  AW  linear coefficient address, 0..MAX_COEFF-1
- oWrDtRam  out  CW  coefficient write data
- oBusy  out  1  a session is active
- oDone  out  1  one-cycle pulse when a session completes
- oErr  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (iRsn=0 at a clock edge): state=IDLE; count register=0. All outputs 0, including oNumOfCoeff=0. Reset mid-session ends the session immediately: no oDone, and the flag is 0 from the next cycle.
- States: IDLE, WAIT_SYNC, LOAD, FINISH.
- IDLE:
  - iLoadStart with 1<=iLoadNum<=MAX_COEFF: latch iLoadNum into a pending register, clear the address counter, go to WAIT_SYNC.
  - iLoadStart with iLoadNum=0 or >MAX_COEFF: oErr=1 next cycle, stay IDLE.
- WAIT_SYNC:
  - On iEnSample600k=1, go to LOAD; oCoeffUpdateFlag=1 from the next cycle.
  - iLoadStart is ignored in every state other than IDLE.
- LOAD:
  - oCoeffReady=1 (combinational from state=LOAD). A transfer occurs on any edge with iCoeffValid&&oCoeffReady.
  - The cycle after each transfer: oAddrRam=counter, oWrDtRam=iCoeffData, then counter increments. Address and data each change exactly once per transfer, with 1-cycle latency.
  - Between transfers, oAddrRam and oWrDtRam hold their values. Re-presenting the same address and data is benign.
  - The transfer with counter=pending-1 moves the state to FINISH. oCoeffReady is 0 from the following cycle, so no extra beat is ever accepted.
  - Host stalls (valid low) of any length are allowed. iEnSample600k is ignored during LOAD.
- FINISH (exactly 1 cycle): oCoeffUpdateFlag stays 1 so the last write completes. On exit:
  - oCoeffUpdateFlag=0
  - oNumOfCoeff takes the pending value
  - oDone=1 for one cycle
  - state returns to IDLE
- oBusy=1 in WAIT_SYNC, LOAD and FINISH.
- iLoadAbort in WAIT_SYNC, LOAD or FINISH:
  - next cycle the state is IDLE and oCoeffUpdateFlag=0
  - oNumOfCoeff is unchanged and no oDone is issued
  - addresses already written stay written
- Priority on the same edge: iRsn > iLoadAbort > transfer > iEnSample600k.
- The counter never exceeds MAX_COEFF-1. oAddrRam never takes a value at or above the pending count.

Test Plan:
- Reset with all inputs 0 -> every output 0; oNumOfCoeff=0.
- Start with iLoadNum=4; strobe 3 cycles later; host streams 0x0011, 0x0022, 0x0033, 0x0044 back to back -> flag rises the cycle after the strobe. oAddrRam/oWrDtRam show 0/0x0011 .. 3/0x0044 on consecutive cycles. FINISH holds the flag 1 extra cycle, then the flag falls, oDone pulses once, and oNumOfCoeff=4.
- Start with iLoadNum=40; host valid toggles randomly -> exactly 40 writes, addresses 0..39 in order, each data word matches its host word. oCoeffReady=0 after the 40th beat; oNumOfCoeff=40.
- Start with iLoadNum=0, then with iLoadNum=41 -> one oErr pulse each; oBusy stays 0; flag stays 0.
- Load of 10 with abort after 5 beats -> flag 0 next cycle, no oDone, oNumOfCoeff keeps its prior value. A following start with iLoadNum=10 writes addresses from 0.
- Start pulse during WAIT_SYNC with a different iLoadNum, and an iEnSample600k pulse during LOAD -> both ignored; the original count is loaded. A reset asserted mid-LOAD zeroes all outputs on the next cycle.
